// File: rtl/exec_stage_sequencer_pkg.sv
`default_nettype none
// =============================================================================
// Module   : exec_stage_sequencer_pkg
// Purpose  : Shared constants and types for the multi-cycle stage sequencer:
//            state encoding, fault codes and the PC source select values that
//            the PC mux decodes.
// Ports    : none (package)
// Revision : 1.0 - initial release
// =============================================================================
package exec_stage_sequencer_pkg;

   // State encoding, 3 bits, IDLE=0 .. HALTED=6
   localparam logic [2:0] c_st_idle      = 3'd0;
   localparam logic [2:0] c_st_fetch     = 3'd1;
   localparam logic [2:0] c_st_decode    = 3'd2;
   localparam logic [2:0] c_st_execute   = 3'd3;
   localparam logic [2:0] c_st_memory    = 3'd4;
   localparam logic [2:0] c_st_writeback = 3'd5;
   localparam logic [2:0] c_st_halted    = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE      = c_st_idle,
      S_FETCH     = c_st_fetch,
      S_DECODE    = c_st_decode,
      S_EXECUTE   = c_st_execute,
      S_MEMORY    = c_st_memory,
      S_WRITEBACK = c_st_writeback,
      S_HALTED    = c_st_halted
   } seq_state_t;

   // Fault codes reported on fault_code
   localparam logic [1:0] c_fc_none     = 2'b00;
   localparam logic [1:0] c_fc_illegal  = 2'b01;
   localparam logic [1:0] c_fc_imem_to  = 2'b10;
   localparam logic [1:0] c_fc_dmem_to  = 2'b11;

   // PC source select, shared with the PC mux
   localparam logic c_pc_src_plus4  = 1'b0;
   localparam logic c_pc_src_target = 1'b1;

   // Width of the shared handshake wait counter
   localparam int c_wait_cnt_w = 8;

endpackage
`default_nettype wire

// File: rtl/exec_stage_sequencer_if.sv
`default_nettype none
// =============================================================================
// Module   : exec_stage_sequencer_if
// Purpose  : Handshake / control bundle between the stage sequencer and the
//            RV32I datapath.
// Modports : master - sequencer side (drives enables, requests, status)
//            slave  - datapath side (drives start/halt, readies, decode flags)
// Signals  : start, halt_req, imem_req/imem_ready, dmem_req/dmem_ready,
//            is_load, is_store, illegal_instr, pc_sel, if_en..wb_en, pc_en,
//            pc_src, busy, halted, fault, fault_code[1:0]
// Revision : 1.0 - initial release
// =============================================================================
interface exec_stage_sequencer_if;
   logic       start;
   logic       halt_req;
   logic       imem_req;
   logic       imem_ready;
   logic       dmem_req;
   logic       dmem_ready;
   logic       is_load;
   logic       is_store;
   logic       illegal_instr;
   logic       pc_sel;
   logic       if_en;
   logic       id_en;
   logic       ex_en;
   logic       mem_en;
   logic       wb_en;
   logic       pc_en;
   logic       pc_src;
   logic       busy;
   logic       halted;
   logic       fault;
   logic [1:0] fault_code;

   modport master (
      input  start, halt_req, imem_ready, dmem_ready,
             is_load, is_store, illegal_instr, pc_sel,
      output imem_req, dmem_req, if_en, id_en, ex_en, mem_en, wb_en,
             pc_en, pc_src, busy, halted, fault, fault_code
   );

   modport slave (
      output start, halt_req, imem_ready, dmem_ready,
             is_load, is_store, illegal_instr, pc_sel,
      input  imem_req, dmem_req, if_en, id_en, ex_en, mem_en, wb_en,
             pc_en, pc_src, busy, halted, fault, fault_code
   );
endinterface
`default_nettype wire

// File: rtl/exec_stage_sequencer_seq_wait_timer.sv
`default_nettype none
// =============================================================================
// Module   : seq_wait_timer
// Purpose  : 8-bit handshake wait counter shared by FETCH and MEMORY. Counts
//            not-ready cycles and flags the cycle whose increment would reach
//            MEM_TIMEOUT.
// Ports    : clk, rst  - clock, synchronous active-high reset
//            i_clr     - force counter to 0 (has priority over i_en)
//            i_en      - count this cycle (waiting, ready low)
//            o_hit     - this wait cycle is the MEM_TIMEOUT-th one
// Revision : 1.0 - initial release
// =============================================================================
module seq_wait_timer
   import exec_stage_sequencer_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic i_clr,
   input  wire logic i_en,
   output logic      o_hit
);

   // The counter holds the number of wait cycles already spent; the current
   // wait cycle is the last allowed one when that number is MEM_TIMEOUT-1.
   localparam logic [c_wait_cnt_w-1:0] c_hit_val = c_wait_cnt_w'(MEM_TIMEOUT - 1);

   logic [c_wait_cnt_w-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_hit = i_en && (r_cnt == c_hit_val);

endmodule
`default_nettype wire

// File: rtl/exec_stage_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : exec_stage_sequencer
// Purpose  : Multi-cycle controller for the non-pipelined RV32I core. Steps
//            FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with one-hot stage enables,
//            waits on memory ready handshakes, strobes the PC and stops on
//            halt request, illegal instruction or memory timeout.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            bus (master)    - handshake / control bundle
//            cycle_cnt       - busy-cycle counter   (STAGE_SEQ_PERF_EN only)
//            instret_cnt     - retired instr counter (STAGE_SEQ_PERF_EN only)
// Config   : STAGE_SEQ_PERF_EN - adds the two performance counters
// Revision : 1.0 - initial release
// =============================================================================
module exec_stage_sequencer
   import exec_stage_sequencer_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255
) (
   input  wire logic                    clk,
   input  wire logic                    rst,
   exec_stage_sequencer_if.master       bus
`ifdef STAGE_SEQ_PERF_EN
   ,
   output logic [31:0]                  cycle_cnt,
   output logic [31:0]                  instret_cnt
`endif
);

   seq_state_t r_state;
   seq_state_t w_next;
   logic       r_fault;
   logic [1:0] r_fault_code;

   logic       w_fault_set;
   logic [1:0] w_fault_code_nxt;
   logic       w_timer_clr;
   logic       w_timer_en;
   logic       w_timer_hit;

   logic       w_imem_req, w_dmem_req;
   logic       w_if_en, w_id_en, w_ex_en, w_mem_en, w_wb_en;
   logic       w_pc_en, w_pc_src, w_busy, w_halted;

   // -------------------------------------------------------------------------
   // Shared wait timer. Cleared whenever the state is not a wait state or is
   // about to change, so every entry into FETCH/MEMORY starts from zero.
   // -------------------------------------------------------------------------
   assign w_timer_en  = ((r_state == S_FETCH)  && !bus.imem_ready) ||
                        ((r_state == S_MEMORY) && !bus.dmem_ready);
   assign w_timer_clr = ((r_state != S_FETCH) && (r_state != S_MEMORY)) ||
                        (w_next != r_state);

   seq_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_wait_timer (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_timer_clr),
      .i_en  (w_timer_en),
      .o_hit (w_timer_hit)
   );

   // -------------------------------------------------------------------------
   // State register and sticky fault
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_fault      <= 1'b0;
         r_fault_code <= c_fc_none;
      end else begin
         r_state <= w_next;
         if (w_fault_set) begin
            r_fault      <= 1'b1;
            r_fault_code <= w_fault_code_nxt;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and output decode
   // -------------------------------------------------------------------------
   always_comb begin
      w_next           = r_state;
      w_fault_set      = 1'b0;
      w_fault_code_nxt = c_fc_none;
      w_imem_req       = 1'b0;
      w_dmem_req       = 1'b0;
      w_if_en          = 1'b0;
      w_id_en          = 1'b0;
      w_ex_en          = 1'b0;
      w_mem_en         = 1'b0;
      w_wb_en          = 1'b0;
      w_pc_en          = 1'b0;
      w_pc_src         = c_pc_src_plus4;
      w_busy           = 1'b0;
      w_halted         = 1'b0;

      case (r_state)
         S_IDLE: begin
            // start wins over a simultaneous halt_req here
            if (bus.start) w_next = S_FETCH;
         end
         S_FETCH: begin
            w_busy     = 1'b1;
            w_imem_req = 1'b1;
            if (bus.imem_ready) begin
               // ready on the final wait cycle still wins over the timeout
               w_if_en = 1'b1;
               w_next  = S_DECODE;
            end else if (w_timer_hit) begin
               w_next           = S_HALTED;
               w_fault_set      = 1'b1;
               w_fault_code_nxt = c_fc_imem_to;
            end
         end
         S_DECODE: begin
            w_busy  = 1'b1;
            w_id_en = 1'b1;
            w_next  = S_EXECUTE;
         end
         S_EXECUTE: begin
            w_busy  = 1'b1;
            w_ex_en = 1'b1;
            if (bus.illegal_instr) begin
               w_next           = S_HALTED;
               w_fault_set      = 1'b1;
               w_fault_code_nxt = c_fc_illegal;
            end else if (bus.is_load || bus.is_store) begin
               w_next = S_MEMORY;
            end else begin
               w_next = S_WRITEBACK;
            end
         end
         S_MEMORY: begin
            w_busy     = 1'b1;
            w_dmem_req = 1'b1;
            if (bus.dmem_ready) begin
               w_mem_en = 1'b1;
               w_next   = S_WRITEBACK;
            end else if (w_timer_hit) begin
               w_next           = S_HALTED;
               w_fault_set      = 1'b1;
               w_fault_code_nxt = c_fc_dmem_to;
            end
         end
         S_WRITEBACK: begin
            w_busy   = 1'b1;
            w_wb_en  = 1'b1;
            w_pc_en  = 1'b1;
            w_pc_src = bus.pc_sel ? c_pc_src_target : c_pc_src_plus4;
            w_next   = bus.halt_req ? S_HALTED : S_FETCH;
         end
         S_HALTED: begin
            w_halted = 1'b1;
            // a faulted core only leaves HALTED through rst
            if (!r_fault && bus.start) w_next = S_FETCH;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   assign bus.imem_req   = w_imem_req;
   assign bus.dmem_req   = w_dmem_req;
   assign bus.if_en      = w_if_en;
   assign bus.id_en      = w_id_en;
   assign bus.ex_en      = w_ex_en;
   assign bus.mem_en     = w_mem_en;
   assign bus.wb_en      = w_wb_en;
   assign bus.pc_en      = w_pc_en;
   assign bus.pc_src     = w_pc_src;
   assign bus.busy       = w_busy;
   assign bus.halted     = w_halted;
   assign bus.fault      = r_fault;
   assign bus.fault_code = r_fault_code;

`ifdef STAGE_SEQ_PERF_EN
   // -------------------------------------------------------------------------
   // Performance counters, wrap modulo 2^32
   // -------------------------------------------------------------------------
   logic [31:0] r_cycle_cnt;
   logic [31:0] r_instret_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cycle_cnt   <= '0;
         r_instret_cnt <= '0;
      end else begin
         if (w_busy)  r_cycle_cnt   <= r_cycle_cnt + 32'd1;
         if (w_wb_en) r_instret_cnt <= r_instret_cnt + 32'd1;
      end
   end

   assign cycle_cnt   = r_cycle_cnt;
   assign instret_cnt = r_instret_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_exec_stage_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : tb_exec_stage_sequencer
// Purpose  : Self-checking bench for exec_stage_sequencer. A transaction-level
//            model expands each instruction (kind, fetch/data wait lengths,
//            branch flag, halt request, optional mid-flight reset) into a
//            per-cycle list of inputs and expected outputs; one process plays
//            the list into the DUT and compares every cycle.
// Config   : STAGE_SEQ_PERF_EN - also compares cycle_cnt / instret_cnt
// Revision : 1.0 - initial release
// =============================================================================
module tb_exec_stage_sequencer;

   localparam int T = 4;   // MEM_TIMEOUT used for the DUT

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   exec_stage_sequencer_if bus();

`ifdef STAGE_SEQ_PERF_EN
   logic [31:0] cycle_cnt;
   logic [31:0] instret_cnt;
`endif

   exec_stage_sequencer #(
      .MEM_TIMEOUT (T)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus)
`ifdef STAGE_SEQ_PERF_EN
      ,
      .cycle_cnt   (cycle_cnt),
      .instret_cnt (instret_cnt)
`endif
   );

   typedef struct {
      bit          rst, start, halt_req, imem_ready, dmem_ready;
      bit          is_load, is_store, illegal, pc_sel;
      bit          chk;
      logic [4:0]  en;          // {wb, mem, ex, id, if}
      bit          imem_req, dmem_req, pc_en, pc_src, busy, halted, fault;
      logic [1:0]  code;
      logic [31:0] cyc, ret;
   } rec_t;

   typedef enum int {M_IDLE, M_RUN, M_HALTC, M_HALTF} mode_t;

   rec_t        q[$];
   mode_t       m_mode;
   bit          m_fault;
   logic [1:0]  m_code;
   int unsigned m_cyc, m_ret;
   int          abort_in = -1;
   bit          aborted;
   int          errors = 0;
   int          checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic bit rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // A cycle record with random don't-care inputs and idle-looking outputs.
   function automatic rec_t base();
      rec_t r;
      r.rst = 0; r.chk = 1;
      r.start = rb(); r.halt_req = rb(); r.imem_ready = rb(); r.dmem_ready = rb();
      r.is_load = rb(); r.is_store = rb(); r.illegal = rb(); r.pc_sel = rb();
      r.en = '0; r.imem_req = 0; r.dmem_req = 0; r.pc_en = 0; r.pc_src = 0;
      r.busy = 0; r.halted = 0;
      r.fault = m_fault; r.code = m_code; r.cyc = m_cyc; r.ret = m_ret;
      return r;
   endfunction

   function automatic void push(rec_t r);
      if (abort_in == 0) begin
         r.rst   = 1;
         aborted = 1;
      end
      if (abort_in >= 0) abort_in--;
      q.push_back(r);
   endfunction

   function automatic void model_reset();
      m_fault = 0; m_code = 2'b00; m_cyc = 0; m_ret = 0;
      m_mode = M_IDLE; aborted = 0; abort_in = -1;
   endfunction

   function automatic bit in_halt();
      return (m_mode == M_HALTC) || (m_mode == M_HALTF);
   endfunction

   // One IDLE or HALTED cycle.
   task automatic rest_cycle(input bit st, input bit hq = 0);
      rec_t r = base();
      r.start = st;
      if (hq) r.halt_req = 1;
      r.halted = in_halt();
      push(r);
      if (st && (m_mode == M_IDLE || m_mode == M_HALTC)) m_mode = M_RUN;
   endtask

   task automatic do_reset(input bit chk = 1);
      rec_t r = base();
      r.rst = 1; r.chk = chk; r.halted = in_halt();
      push(r);
      model_reset();
   endtask

   // Expands one instruction into its cycles. fw/mw = not-ready cycles
   // before the ready cycle; a wait of T or more ends in a timeout.
   task automatic instr(input bit ld, st, ill, psel, hreq, input int fw, mw);
      rec_t r;
      for (int i = 0; ; i++) begin
         r = base(); r.busy = 1; r.imem_req = 1;
         r.imem_ready = (i >= fw);
         if (r.imem_ready) r.en = 5'b00001;
         push(r); m_cyc++;
         if (aborted || r.imem_ready) break;
         if (i == T - 1) begin
            m_fault = 1; m_code = 2'b10; m_mode = M_HALTF;
            return;
         end
      end
      if (aborted) return;
      r = base(); r.busy = 1; r.en = 5'b00010;
      push(r); m_cyc++;
      if (aborted) return;
      r = base(); r.busy = 1; r.en = 5'b00100;
      r.is_load = ld; r.is_store = st; r.illegal = ill;
      push(r); m_cyc++;
      if (aborted) return;
      if (ill) begin
         m_fault = 1; m_code = 2'b01; m_mode = M_HALTF;
         return;
      end
      if (ld || st) begin
         for (int i = 0; ; i++) begin
            r = base(); r.busy = 1; r.dmem_req = 1;
            r.dmem_ready = (i >= mw);
            if (r.dmem_ready) r.en = 5'b01000;
            push(r); m_cyc++;
            if (aborted || r.dmem_ready) break;
            if (i == T - 1) begin
               m_fault = 1; m_code = 2'b11; m_mode = M_HALTF;
               return;
            end
         end
         if (aborted) return;
      end
      r = base(); r.busy = 1; r.en = 5'b10000; r.pc_en = 1;
      r.pc_sel = psel; r.pc_src = psel; r.halt_req = hreq;
      push(r); m_cyc++; m_ret++;
      if (hreq) m_mode = M_HALTC;
   endtask

   task automatic run_instr(input bit ld, st, ill, psel, hreq, input int fw, mw);
      instr(ld, st, ill, psel, hreq, fw, mw);
      if (aborted) model_reset();
      abort_in = -1;
   endtask

   task automatic build();
      int n0;
      model_reset();
      do_reset(0);
      do_reset(1);
      rest_cycle(0);
      rest_cycle(1, 1);                          // start beats halt_req in IDLE
      n0 = q.size();
      run_instr(1, 0, 0, 0, 0, 0, 3);            // load, 3 data wait cycles
      check("model_load_len", q.size() - n0, 8);
      check("model_load_cyc", m_cyc, 8);
      check("model_load_ret", m_ret, 1);
      n0 = q.size();
      run_instr(0, 0, 0, 0, 0, 0, 0);            // ALU op
      check("model_alu_len", q.size() - n0, 4);
      check("model_alu_wb_en", q[n0 + 3].en, 5'b10000);
      check("model_alu_id_en", q[n0 + 1].en, 5'b00010);
      run_instr(0, 0, 0, 1, 0, 0, 0);            // taken branch
      run_instr(0, 0, 0, 0, 0, 1, 0);            // not taken, 1 fetch wait
      run_instr(0, 1, 0, 1, 1, 0, 0);            // store then halt
      rest_cycle(0); rest_cycle(0); rest_cycle(1);
      run_instr(0, 0, 1, 0, 0, 0, 0);            // illegal
      check("model_ill_code", m_code, 2'b01);
      rest_cycle(1); rest_cycle(1);
      do_reset();
      rest_cycle(1);
      abort_in = 4;                              // reset on 2nd MEMORY wait
      run_instr(1, 0, 0, 0, 0, 0, 6);
      rest_cycle(0);
      rest_cycle(1);
      n0 = q.size();
      run_instr(0, 0, 0, 0, 0, 10, 0);           // imem timeout
      check("model_imem_to_len", q.size() - n0, T);
      check("model_imem_to_code", m_code, 2'b10);
      rest_cycle(1); rest_cycle(1);
      do_reset();

      while (q.size() < 2500) begin
         case (m_mode)
            M_IDLE, M_HALTC: rest_cycle(rb());
            M_HALTF: begin
               rest_cycle(rb());
               if ($urandom_range(0, 2) == 0) do_reset();
            end
            default: begin
               int kind = int'($urandom_range(0, 3));
               int fw   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(2, 6))
                                                      : int'($urandom_range(0, 1));
               int mw   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(2, 6))
                                                      : int'($urandom_range(0, 1));
               if ($urandom_range(0, 24) == 0) abort_in = int'($urandom_range(0, 7));
               run_instr(kind == 1, kind == 2, $urandom_range(0, 15) == 0, rb(),
                         $urandom_range(0, 7) == 0, fw, mw);
            end
         endcase
      end
   endtask

   initial begin
      bus.start = 0; bus.halt_req = 0; bus.imem_ready = 0; bus.dmem_ready = 0;
      bus.is_load = 0; bus.is_store = 0; bus.illegal_instr = 0; bus.pc_sel = 0;
      build();
      foreach (q[k]) begin
         @(posedge clk);
         #1;
         rst               = q[k].rst;
         bus.start         = q[k].start;
         bus.halt_req      = q[k].halt_req;
         bus.imem_ready    = q[k].imem_ready;
         bus.dmem_ready    = q[k].dmem_ready;
         bus.is_load       = q[k].is_load;
         bus.is_store      = q[k].is_store;
         bus.illegal_instr = q[k].illegal;
         bus.pc_sel        = q[k].pc_sel;
         @(negedge clk);
         if (q[k].chk) begin
            check("stage_en", {bus.wb_en, bus.mem_en, bus.ex_en, bus.id_en, bus.if_en}, q[k].en);
            check("imem_req", bus.imem_req, q[k].imem_req);
            check("dmem_req", bus.dmem_req, q[k].dmem_req);
            check("pc_en", bus.pc_en, q[k].pc_en);
            check("pc_src", bus.pc_src, q[k].pc_src);
            check("busy", bus.busy, q[k].busy);
            check("halted", bus.halted, q[k].halted);
            check("fault", bus.fault, q[k].fault);
            check("fault_code", bus.fault_code, q[k].code);
`ifdef STAGE_SEQ_PERF_EN
            check("cycle_cnt", cycle_cnt, q[k].cyc);
            check("instret_cnt", instret_cnt, q[k].ret);
`endif
         end
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
